// File: rtl/ballot_capture_pkg.sv
// ============================================================================
// Module : ballot_capture_pkg
// Brief  : Shared types, widths and helpers for the ballot capture front end.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ballot_capture_pkg;

    localparam int BALLOT_W = 3;
    localparam int CNT_W    = 4;

    typedef enum logic [0:0] {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Single-digit ballot counter: wraps at max straight back to zero.
    function automatic logic [CNT_W-1:0] cnt_wrap_inc(input logic [CNT_W-1:0] cnt,
                                                      input logic [CNT_W-1:0] max);
        return (cnt == max) ? '0 : cnt + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module : btn_debounce
// Brief  : Synchroniser, stability counter and rising-edge press detector.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk100MHz,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam int c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_stable;
    logic                   r_stable_d;
    logic                   r_armed;
    logic                   w_synced;

    // The synchroniser keeps sampling through reset so that a button held
    // across reset is seen as high the moment reset lifts.
    always_ff @(posedge clk100MHz) begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
    end

    assign w_synced = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            r_cnt      <= '0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_stable_d <= r_stable;
            // A press only counts once the button has been seen released.
            if (!r_stable && !w_synced) begin
                r_armed <= 1'b1;
            end
            if (w_synced == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                r_stable <= w_synced;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign press = r_stable & ~r_stable_d & r_armed;

endmodule

`default_nettype wire

// File: rtl/ballot_capture.sv
// ============================================================================
// Module : ballot_capture
// Brief  : Conditions voter/cast buttons, edits a pending ballot, commits it.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ballot_capture
    import ballot_capture_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2,
    parameter int CNT_MAX         = 9
) (
    input  logic                clk100MHz,
    input  logic                rst,
    input  logic                A_raw,
    input  logic                B_raw,
    input  logic                C_raw,
    input  logic                cast_raw,
    output logic                A,
    output logic                B,
    output logic                C,
    output logic [BALLOT_W-1:0] pending,
    output logic                locked,
    output logic                cast_pulse,
    output logic [CNT_W-1:0]    ballot_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(CNT_MAX);

    // Bit order {A, B, C, cast} throughout.
    logic [3:0]          w_raw;
    logic [3:0]          w_press;

    state_t              r_state;
    state_t              w_state_next;
    logic [BALLOT_W-1:0] r_pending;
    logic [BALLOT_W-1:0] w_pending_next;
    logic [BALLOT_W-1:0] r_vote;
    logic [BALLOT_W-1:0] w_vote_next;
    logic                r_cast_pulse;
    logic                w_cast_pulse_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_next;

    assign w_raw = {A_raw, B_raw, C_raw, cast_raw};

    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_btn (
            .clk100MHz(clk100MHz),
            .rst      (rst),
            .raw      (w_raw[gi]),
            .press    (w_press[gi])
        );
    end

    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            r_state      <= ST_OPEN;
            r_pending    <= '0;
            r_vote       <= '0;
            r_cast_pulse <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_next;
            r_pending    <= w_pending_next;
            r_vote       <= w_vote_next;
            r_cast_pulse <= w_cast_pulse_next;
            r_cnt        <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_pending_next    = r_pending;
        w_vote_next       = r_vote;
        w_cast_pulse_next = 1'b0;
        w_cnt_next        = r_cnt;
        case (r_state)
            ST_OPEN: begin
                // Cast takes priority: a simultaneous voter toggle is dropped.
                if (w_press[0]) begin
                    w_vote_next       = r_pending;
                    w_cast_pulse_next = 1'b1;
                    w_cnt_next        = cnt_wrap_inc(r_cnt, c_cnt_max);
                    w_state_next      = ST_LOCKED;
                end else begin
                    w_pending_next = r_pending ^ w_press[3:1];
                end
            end
            ST_LOCKED: begin
                if (w_press[0]) begin
                    w_pending_next = '0;
                    w_state_next   = ST_OPEN;
                end
            end
            default: begin
                w_state_next = ST_OPEN;
            end
        endcase
    end

    assign {A, B, C}  = r_vote;
    assign pending    = r_pending;
    assign locked     = (r_state == ST_LOCKED);
    assign cast_pulse = r_cast_pulse;
    assign ballot_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ballot_capture.sv
// ============================================================================
// Module : tb_ballot_capture
// Brief  : Randomised button stimulus against a behavioural ballot model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ballot_capture;

    localparam int DEB  = 4;
    localparam int SYN  = 2;
    localparam int CMAX = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_raw = 1'b1, b_raw = 1'b1, c_raw = 1'b1, cast_raw = 1'b1;
    logic       A, B, C, locked, cast_pulse;
    logic [2:0] pending;
    logic [3:0] ballot_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int n_pulses = 0;

    always #5 clk = ~clk;

    ballot_capture #(
        .DEBOUNCE_CYCLES(DEB),
        .SYNC_STAGES    (SYN),
        .CNT_MAX        (CMAX)
    ) dut (
        .clk100MHz (clk),
        .rst       (rst),
        .A_raw     (a_raw),
        .B_raw     (b_raw),
        .C_raw     (c_raw),
        .cast_raw  (cast_raw),
        .A         (A),
        .B         (B),
        .C         (C),
        .pending   (pending),
        .locked    (locked),
        .cast_pulse(cast_pulse),
        .ballot_cnt(ballot_cnt)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a button level is accepted once its synchronised
    // value has been identical for DEB consecutive post-reset samples; a press
    // is an accepted rise that follows an accepted-and-seen release.
    logic [3:0] h_old = '0, h_new = '0;
    logic [3:0] m_stable, m_stable_d, m_armed, m_last;
    int         m_run [4];
    logic       m_locked, m_pulse, m_valid = 1'b0;
    logic [2:0] m_pending, m_vote;
    logic [3:0] m_cnt;

    task automatic model_step();
        logic [3:0] synced, p;
        synced = h_old;
        h_old  = h_new;
        h_new  = {a_raw, b_raw, c_raw, cast_raw};
        if (rst) begin
            m_valid    = 1'b1;
            m_stable   = '0;
            m_stable_d = '0;
            m_armed    = '0;
            m_last     = '0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            m_locked   = 1'b0;
            m_pulse    = 1'b0;
            m_pending  = '0;
            m_vote     = '0;
            m_cnt      = '0;
        end else begin
            p       = m_stable & ~m_stable_d & m_armed;
            m_pulse = 1'b0;
            if (!m_locked) begin
                if (p[0]) begin
                    m_vote   = m_pending;
                    m_locked = 1'b1;
                    m_pulse  = 1'b1;
                    m_cnt    = 4'((int'(m_cnt) + 1) % (CMAX + 1));
                end else begin
                    m_pending = m_pending ^ p[3:1];
                end
            end else if (p[0]) begin
                m_pending = '0;
                m_locked  = 1'b0;
            end
            for (int i = 0; i < 4; i++) begin
                if (!m_stable[i] && !synced[i]) m_armed[i] = 1'b1;
                m_stable_d[i] = m_stable[i];
                if (m_run[i] > 0 && synced[i] == m_last[i]) begin
                    if (m_run[i] < DEB) m_run[i]++;
                end else begin
                    m_last[i] = synced[i];
                    m_run[i]  = 1;
                end
                if (m_run[i] >= DEB) m_stable[i] = m_last[i];
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("A",          {7'b0, A},          {7'b0, m_vote[2]});
            chk("B",          {7'b0, B},          {7'b0, m_vote[1]});
            chk("C",          {7'b0, C},          {7'b0, m_vote[0]});
            chk("pending",    {5'b0, pending},    {5'b0, m_pending});
            chk("locked",     {7'b0, locked},     {7'b0, m_locked});
            chk("cast_pulse", {7'b0, cast_pulse}, {7'b0, m_pulse});
            chk("ballot_cnt", {4'b0, ballot_cnt}, {4'b0, m_cnt});
        end
        if (cast_pulse === 1'b1) n_pulses++;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_raw(input logic [3:0] v);
        {a_raw, b_raw, c_raw, cast_raw} = v;
    endtask

    // Press and release the buttons in mask m, optionally with contact bounce.
    task automatic press(input logic [3:0] m, input bit bounce);
        logic [3:0] cur;
        cur = {a_raw, b_raw, c_raw, cast_raw};
        if (bounce) begin
            repeat ($urandom_range(1, 6)) begin
                cur = cur ^ (m & 4'($urandom));
                set_raw(cur);
                cycles(1);
            end
        end
        cur = cur | m;
        set_raw(cur);
        cycles(12);
        if (bounce) begin
            repeat ($urandom_range(1, 6)) begin
                cur = cur ^ (m & 4'($urandom));
                set_raw(cur);
                cycles(1);
            end
        end
        cur = cur & ~m;
        set_raw(cur);
        cycles(12);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        cycles(n);
        rst = 1'b0;
    endtask

    int p0;

    initial begin
        // Reset with every button held: nothing may register afterwards.
        cycles(3);
        chk("rst_A", {7'b0, A}, 8'd0);
        chk("rst_B", {7'b0, B}, 8'd0);
        chk("rst_C", {7'b0, C}, 8'd0);
        chk("rst_pending", {5'b0, pending}, 8'd0);
        chk("rst_locked", {7'b0, locked}, 8'd0);
        chk("rst_pulse", {7'b0, cast_pulse}, 8'd0);
        chk("rst_cnt", {4'b0, ballot_cnt}, 8'd0);
        rst = 1'b0;
        cycles(20);
        chk("held_pending", {5'b0, pending}, 8'd0);
        chk("held_locked", {7'b0, locked}, 8'd0);
        set_raw(4'b0000);
        cycles(12);

        // A bounces every cycle for 10 cycles, then settles high.
        for (int i = 0; i < 10; i++) begin
            a_raw = ~a_raw;
            cycles(1);
        end
        a_raw = 1'b1;
        cycles(12);
        chk("bounce_pending", {5'b0, pending}, 8'b100);
        a_raw = 1'b0;
        cycles(12);

        // Commit {A,C}.
        press(4'b0010, 1'b0);
        chk("preC_pending", {5'b0, pending}, 8'b101);
        p0 = n_pulses;
        press(4'b0001, 1'b0);
        chk("commit_A", {7'b0, A}, 8'd1);
        chk("commit_B", {7'b0, B}, 8'd0);
        chk("commit_C", {7'b0, C}, 8'd1);
        chk("commit_locked", {7'b0, locked}, 8'd1);
        chk("commit_cnt", {4'b0, ballot_cnt}, 8'd1);
        chk("commit_pulses", 8'(n_pulses - p0), 8'd1);

        // Voter presses ignored while locked.
        press(4'b0100, 1'b0);
        chk("lock_pending", {5'b0, pending}, 8'b101);
        chk("lock_B", {7'b0, B}, 8'd0);
        p0 = n_pulses;
        press(4'b0001, 1'b0);
        chk("reopen_locked", {7'b0, locked}, 8'd0);
        chk("reopen_pending", {5'b0, pending}, 8'd0);
        chk("reopen_ABC", {5'b0, A, B, C}, 8'b101);
        chk("reopen_pulses", 8'(n_pulses - p0), 8'd0);

        // Collision: B toggle and cast in the same cycle, cast wins.
        press(4'b0100, 1'b0);
        chk("coll_pre", {5'b0, pending}, 8'b010);
        press(4'b0101, 1'b0);
        chk("coll_ABC", {5'b0, A, B, C}, 8'b010);
        chk("coll_cnt", {4'b0, ballot_cnt}, 8'd2);
        press(4'b0001, 1'b0);
        chk("coll_reopen", {5'b0, pending}, 8'd0);

        // Counter wrap from a fresh reset.
        do_reset(3);
        chk("wrap_rst_cnt", {4'b0, ballot_cnt}, 8'd0);
        for (int i = 1; i <= 10; i++) begin
            press(4'b0001, 1'b0);
            chk("wrap_cnt", {4'b0, ballot_cnt}, 8'(i % 10));
            press(4'b0001, 1'b0);
        end

        // Reset lands while A is mid-debounce; A stays held afterwards.
        a_raw = 1'b1;
        cycles(3);
        do_reset(3);
        cycles(15);
        chk("midrst_pending", {5'b0, pending}, 8'd0);
        chk("midrst_A", {7'b0, A}, 8'd0);
        chk("midrst_cnt", {4'b0, ballot_cnt}, 8'd0);
        a_raw = 1'b0;
        cycles(12);

        // Randomised presses with bounce and the occasional reset.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 14) == 0) do_reset($urandom_range(2, 4));
            press(4'($urandom_range(1, 15)), bit'($urandom_range(0, 1)));
        end

        cycles(5);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
